// File: rtl/jtframe_romrq_arb_if.sv
// Bundle of the ROM client slots and the SDRAM controller read port
// serviced by jtframe_romrq_arb.
interface jtframe_romrq_arb_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 18
);
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                sdram_req;
    logic [21:0]         sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [31:0]         data_read;
    logic                downloading;
    logic                loop_rst;
    logic                vblank;
    logic                refresh_en;

    modport slave (
        input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
               downloading, loop_rst, vblank,
        output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );

    modport master (
        output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
               downloading, loop_rst, vblank,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
endinterface

// File: rtl/jtframe_romrq_arb.sv
// N-slot SDRAM read arbiter: one-word tag cache per slot, per-slot address
// offset, fixed-priority or round-robin grant, one outstanding read at a time.
module jtframe_romrq_arb #(
    parameter int              SLOTS   = 4,
    parameter int              AW      = 18,
    parameter logic [22*8-1:0] OFFSETS = {8{22'd0}},
    parameter int              RR      = 0
) (
    input  logic               clk,
    input  logic               rst,
    jtframe_romrq_arb_if.slave bus
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] { ST_IDLE, ST_REQ, ST_WAIT } state_t;

    state_t              state, next_state;
    logic                clr;
    logic [SLOTS-1:0]    valid, hit, pend, ok_q;
    logic [AW-1:0]       tag [SLOTS];
    logic [SLOTS*32-1:0] dout_q;
    logic [IW-1:0]       gnt, win, rr_ptr;
    logic [AW-1:0]       win_addr;
    logic [21:0]         win_off, addr_q;
    logic                any_pend, grant, fill, refresh_q;

    assign clr            = rst | bus.loop_rst;
    assign any_pend       = |pend;
    assign bus.slot_ok    = ok_q;
    assign bus.slot_dout  = dout_q;
    assign bus.sdram_addr = addr_q;
    assign bus.refresh_en = refresh_q;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            hit[i]  = valid[i] && (tag[i] == bus.slot_addr[AW*i +: AW]);
            pend[i] = bus.slot_cs[i] && !hit[i] && !bus.downloading;
        end
    end

    // Scan from lowest to highest priority so the last pending match wins.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int k = SLOTS; k >= 1; k--) begin
            if (RR != 0) idx = (int'(rr_ptr) + k) % SLOTS;
            else         idx = k - 1;
            if (pend[idx]) win = IW'(idx);
        end
        win_addr = bus.slot_addr[AW*int'(win) +: AW];
        win_off  = OFFSETS[22*int'(win) +: 22];
    end

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (any_pend) next_state = ST_REQ;
            ST_REQ:  if (bus.sdram_ack) next_state = bus.data_rdy ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (bus.data_rdy) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.sdram_req = (state == ST_REQ);
        grant         = (state == ST_IDLE) && any_pend;
        fill          = ((state == ST_REQ) && bus.sdram_ack && bus.data_rdy) ||
                        ((state == ST_WAIT) && bus.data_rdy);
    end

    // The granted slot's valid bit drops with the new tag so the old word is
    // never reported as a hit for the address being fetched.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid     <= '0;
            ok_q      <= '0;
            dout_q    <= '0;
            addr_q    <= '0;
            refresh_q <= 1'b0;
            gnt       <= '0;
            rr_ptr    <= IW'(SLOTS - 1);
            for (int i = 0; i < SLOTS; i++) tag[i] <= '0;
        end else begin
            ok_q      <= bus.slot_cs & hit & {SLOTS{!bus.downloading}};
            refresh_q <= bus.vblank && (state == ST_IDLE) && !any_pend;
            if (grant) begin
                gnt        <= win;
                tag[win]   <= win_addr;
                valid[win] <= 1'b0;
                addr_q     <= 22'(win_addr) + win_off;
            end
            if (fill) begin
                dout_q[32*int'(gnt) +: 32] <= bus.data_read;
                if (!bus.downloading) valid[gnt] <= 1'b1;
                if (RR != 0) rr_ptr <= gnt;
            end
            if (bus.downloading) valid <= '0;
        end
    end
endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Self-checking bench for jtframe_romrq_arb: a fixed-priority instance and a
// round-robin instance, checked against a per-slot one-word cache model.
module tb_jtframe_romrq_arb;
    localparam logic [22*8-1:0] OFF0 = {22'd0, 22'd0, 22'd0, 22'd0,
                                        22'h000010, 22'h3FFFF0, 22'h000400, 22'h002000};
    localparam logic [22*8-1:0] OFF1 = {22'd0, 22'd0, 22'd0, 22'd0,
                                        22'h200000, 22'h000000, 22'h100000, 22'h000000};
    localparam int OFF0_TAB [4] = '{32'h002000, 32'h000400, 32'h3FFFF0, 32'h000010};
    localparam int OFF1_TAB [4] = '{32'h000000, 32'h100000, 32'h000000, 32'h200000};

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    jtframe_romrq_arb_if #(.SLOTS(4), .AW(18)) b0 ();
    jtframe_romrq_arb_if #(.SLOTS(4), .AW(18)) b1 ();

    jtframe_romrq_arb #(.SLOTS(4), .AW(18), .OFFSETS(OFF0), .RR(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    jtframe_romrq_arb #(.SLOTS(4), .AW(18), .OFFSETS(OFF1), .RR(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [21:0] exp_addr(input int d, input int s, input logic [17:0] a);
        int off;
        off = (d == 0) ? OFF0_TAB[s] : OFF1_TAB[s];
        return 22'((off + int'(a)) % 4194304);
    endfunction

    function automatic logic get_req(input int d);
        return (d == 0) ? b0.sdram_req : b1.sdram_req;
    endfunction

    function automatic logic [21:0] get_addr(input int d);
        return (d == 0) ? b0.sdram_addr : b1.sdram_addr;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hs(input int d, input logic ack, input logic rdy, input logic [31:0] data);
        if (d == 0) begin
            b0.sdram_ack = ack; b0.data_rdy = rdy; b0.data_read = data;
        end else begin
            b1.sdram_ack = ack; b1.data_rdy = rdy; b1.data_read = data;
        end
    endtask

    task automatic wait_req(input int d, output logic [21:0] addr, output bit to);
        to   = 1'b1;
        addr = '0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (get_req(d) === 1'b1) begin
                addr = get_addr(d);
                to   = 1'b0;
                break;
            end
        end
    endtask

    // Leaves the bench just after the edge that writes the fill.
    task automatic finish_fetch(input int d, input int ack_dly, input int rdy_dly, input logic [31:0] data);
        for (int n = 0; n < ack_dly; n++) step();
        drive_hs(d, 1'b1, rdy_dly == 0, data);
        step();
        drive_hs(d, 1'b0, 1'b0, 32'h0);
        if (rdy_dly > 0) begin
            for (int n = 1; n < rdy_dly; n++) step();
            drive_hs(d, 1'b0, 1'b1, data);
            step();
            drive_hs(d, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b0.slot_cs = 4'($urandom);  b0.slot_addr = 72'({$urandom, $urandom, $urandom});
        b1.slot_cs = 4'($urandom);  b1.slot_addr = 72'({$urandom, $urandom, $urandom});
        b0.vblank = 1'b1; b0.downloading = 1'b0; b0.loop_rst = 1'b0;
        b1.vblank = 1'b1; b1.downloading = 1'b0; b1.loop_rst = 1'b0;
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        drive_hs(1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        checks++; if (b0.slot_ok !== 4'b0) begin errors++; $display("[TB] FAIL reset_ok: got %b exp 0000", b0.slot_ok); end
        checks++; if (b0.sdram_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b exp 0", b0.sdram_req); end
        checks++; if (b0.sdram_addr !== 22'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h exp 0", b0.sdram_addr); end
        checks++; if (b0.refresh_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_refresh: got %b exp 0", b0.refresh_en); end
        checks++; if (b0.slot_dout !== 128'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h exp 0", b0.slot_dout); end
        checks++; if (b1.slot_ok !== 4'b0 || b1.sdram_req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rr: got ok=%b req=%b exp ok=0000 req=0", b1.slot_ok, b1.sdram_req); end
        rst = 1'b0;
        b0.slot_cs = 4'b0; b1.slot_cs = 4'b0;
        b0.vblank = 1'b0;  b1.vblank = 1'b0;
        step();
    endtask

    task automatic test_basic_fill();
        int reqs;
        b0.slot_addr[0 +: 18] = 18'h100;
        b0.slot_cs = 4'b0001;
        step();
        checks++; if (b0.sdram_req !== 1'b1 || b0.sdram_addr !== 22'h002100) begin
            errors++; $display("[TB] FAIL basic_req: got req=%b addr=%h exp req=1 addr=002100", b0.sdram_req, b0.sdram_addr); end
        checks++; if (b0.slot_ok[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_ok_early: got %b exp 0", b0.slot_ok[0]); end
        drive_hs(0, 1'b1, 1'b0, 32'h0);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        checks++; if (b0.sdram_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_req_drop: got %b exp 0", b0.sdram_req); end
        drive_hs(0, 1'b0, 1'b1, 32'hDEADBEEF);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        checks++; if (b0.slot_ok[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_ok_fill_edge: got %b exp 0", b0.slot_ok[0]); end
        step();
        checks++; if (b0.slot_ok[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_ok: got %b exp 1", b0.slot_ok[0]); end
        checks++; if (b0.slot_dout[31:0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_dout: got %h exp deadbeef", b0.slot_dout[31:0]); end
        reqs = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (b0.sdram_req === 1'b1) reqs++;
        end
        checks++; if (reqs != 0) begin errors++; $display("[TB] FAIL basic_no_refetch: got %0d requests exp 0", reqs); end
        b0.slot_cs = 4'b0;
        step();
        checks++; if (b0.slot_ok[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_ok_cs_drop: got %b exp 0", b0.slot_ok[0]); end
        b0.slot_cs = 4'b0001;
        step();
        checks++; if (b0.slot_ok[0] !== 1'b1 || b0.sdram_req !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_repeat_hit: got ok=%b req=%b exp ok=1 req=0", b0.slot_ok[0], b0.sdram_req); end
        b0.slot_cs = 4'b0;
        step();
    endtask

    task automatic test_random_fills();
        logic [17:0] mt [4];
        bit          mv [4];
        logic [31:0] md [4];
        logic [17:0] a;
        logic [21:0] got;
        logic [31:0] data;
        bit          to;
        int          s;
        for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; mt[i] = '0; md[i] = '0; end
        for (int it = 0; it < 24; it++) begin
            s = int'($urandom_range(0, 3));
            a = (s == 2) ? 18'h3FFF0 + 18'($urandom_range(0, 3)) : 18'h1000 + 18'($urandom_range(0, 3));
            b0.slot_addr[18*s +: 18] = a;
            b0.slot_cs = 4'b1 << s;
            if (mv[s] && mt[s] == a) begin
                step();
                checks++; if (b0.slot_ok[s] !== 1'b1 || b0.sdram_req !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_hit slot%0d: got ok=%b req=%b exp ok=1 req=0", s, b0.slot_ok[s], b0.sdram_req); end
                checks++; if (b0.slot_dout[32*s +: 32] !== md[s]) begin
                    errors++; $display("[TB] FAIL rand_hit_dout slot%0d: got %h exp %h", s, b0.slot_dout[32*s +: 32], md[s]); end
            end else begin
                wait_req(0, got, to);
                checks++; if (to || got !== exp_addr(0, s, a)) begin
                    errors++; $display("[TB] FAIL rand_miss_addr slot%0d: got %h (timeout=%0d) exp %h", s, got, to, exp_addr(0, s, a)); end
                data = $urandom;
                finish_fetch(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), data);
                step();
                checks++; if (b0.slot_ok[s] !== 1'b1 || b0.slot_dout[32*s +: 32] !== data) begin
                    errors++; $display("[TB] FAIL rand_fill slot%0d: got ok=%b dout=%h exp ok=1 dout=%h", s, b0.slot_ok[s], b0.slot_dout[32*s +: 32], data); end
                mv[s] = 1'b1; mt[s] = a; md[s] = data;
            end
            b0.slot_cs = 4'b0;
            step();
        end
    endtask

    task automatic test_fixed_priority();
        logic [17:0] a [4];
        logic [3:0]  pset;
        logic [21:0] got;
        bit          to;
        int          pick;
        a[0] = 18'h2000 + 18'($urandom_range(0, 15));
        a[1] = 18'h0;
        a[2] = 18'h2100 + 18'($urandom_range(0, 15));
        a[3] = 18'h2200 + 18'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) b0.slot_addr[18*i +: 18] = a[i];
        b0.slot_cs = 4'b1101;
        pset = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            pick = -1;
            for (int i = 3; i >= 0; i--) if (pset[i]) pick = i;
            wait_req(0, got, to);
            checks++; if (to || got !== exp_addr(0, pick, a[pick])) begin
                errors++; $display("[TB] FAIL prio_grant%0d: got %h (timeout=%0d) exp slot%0d addr %h", k, got, to, pick, exp_addr(0, pick, a[pick])); end
            finish_fetch(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
            pset[pick] = 1'b0;
        end
        step();
        checks++; if (b0.slot_ok !== 4'b1101) begin errors++; $display("[TB] FAIL prio_ok: got %b exp 1101", b0.slot_ok); end
        b0.slot_cs = 4'b0;
        step();
    endtask

    task automatic test_addr_change();
        logic [21:0] got;
        bit          to;
        logic [31:0] d1, d2;
        d1 = $urandom;
        d2 = ~d1;
        b0.slot_addr[18 +: 18] = 18'h10;
        b0.slot_cs = 4'b0010;
        wait_req(0, got, to);
        checks++; if (to || got !== exp_addr(0, 1, 18'h10)) begin
            errors++; $display("[TB] FAIL chg_first_addr: got %h (timeout=%0d) exp %h", got, to, exp_addr(0, 1, 18'h10)); end
        drive_hs(0, 1'b1, 1'b0, 32'h0);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        b0.slot_addr[18 +: 18] = 18'h11;
        step();
        drive_hs(0, 1'b0, 1'b1, d1);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        checks++; if (b0.slot_ok[1] !== 1'b0) begin errors++; $display("[TB] FAIL chg_ok_after_fill: got %b exp 0", b0.slot_ok[1]); end
        wait_req(0, got, to);
        checks++; if (to || got !== exp_addr(0, 1, 18'h11)) begin
            errors++; $display("[TB] FAIL chg_second_addr: got %h (timeout=%0d) exp %h", got, to, exp_addr(0, 1, 18'h11)); end
        checks++; if (b0.slot_ok[1] !== 1'b0) begin errors++; $display("[TB] FAIL chg_ok_stale: got %b exp 0", b0.slot_ok[1]); end
        finish_fetch(0, 1, 1, d2);
        step();
        checks++; if (b0.slot_ok[1] !== 1'b1 || b0.slot_dout[32 +: 32] !== d2) begin
            errors++; $display("[TB] FAIL chg_second_fill: got ok=%b dout=%h exp ok=1 dout=%h", b0.slot_ok[1], b0.slot_dout[32 +: 32], d2); end
        b0.slot_cs = 4'b0;
        step();
    endtask

    task automatic test_downloading();
        logic [21:0] got;
        bit          to;
        logic [31:0] d2;
        b0.slot_addr[54 +: 18] = 18'h3000;
        b0.slot_cs = 4'b1000;
        wait_req(0, got, to);
        checks++; if (to || got !== exp_addr(0, 3, 18'h3000)) begin
            errors++; $display("[TB] FAIL dl_first_addr: got %h (timeout=%0d) exp %h", got, to, exp_addr(0, 3, 18'h3000)); end
        finish_fetch(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
        step();
        checks++; if (b0.slot_ok[3] !== 1'b1) begin errors++; $display("[TB] FAIL dl_ok_before: got %b exp 1", b0.slot_ok[3]); end
        b0.downloading = 1'b1;
        step();
        checks++; if (b0.slot_ok !== 4'b0) begin errors++; $display("[TB] FAIL dl_ok_drop: got %b exp 0000", b0.slot_ok); end
        step();
        step();
        checks++; if (b0.sdram_req !== 1'b0) begin errors++; $display("[TB] FAIL dl_no_grant: got %b exp 0", b0.sdram_req); end
        b0.downloading = 1'b0;
        wait_req(0, got, to);
        checks++; if (to || got !== exp_addr(0, 3, 18'h3000)) begin
            errors++; $display("[TB] FAIL dl_refetch_addr: got %h (timeout=%0d) exp %h", got, to, exp_addr(0, 3, 18'h3000)); end
        drive_hs(0, 1'b1, 1'b0, 32'h0);
        step();
        b0.downloading = 1'b1;
        drive_hs(0, 1'b0, 1'b1, 32'h0BADF00D);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        b0.downloading = 1'b0;
        checks++; if (b0.slot_ok[3] !== 1'b0) begin errors++; $display("[TB] FAIL dl_inflight_ok: got %b exp 0", b0.slot_ok[3]); end
        step();
        checks++; if (b0.slot_ok[3] !== 1'b0 || b0.sdram_req !== 1'b1) begin
            errors++; $display("[TB] FAIL dl_discarded_fill: got ok=%b req=%b exp ok=0 req=1", b0.slot_ok[3], b0.sdram_req); end
        d2 = $urandom;
        finish_fetch(0, 0, 1, d2);
        step();
        checks++; if (b0.slot_ok[3] !== 1'b1 || b0.slot_dout[96 +: 32] !== d2) begin
            errors++; $display("[TB] FAIL dl_final_fill: got ok=%b dout=%h exp ok=1 dout=%h", b0.slot_ok[3], b0.slot_dout[96 +: 32], d2); end
        b0.slot_cs = 4'b0;
        step();
    endtask

    task automatic test_refresh();
        b0.slot_cs = 4'b0;
        b0.vblank  = 1'b1;
        step();
        step();
        checks++; if (b0.refresh_en !== 1'b1) begin errors++; $display("[TB] FAIL refresh_idle: got %b exp 1", b0.refresh_en); end
        b0.slot_addr[0 +: 18] = 18'h3A00;
        b0.slot_cs = 4'b0001;
        step();
        checks++; if (b0.refresh_en !== 1'b0 || b0.sdram_req !== 1'b1) begin
            errors++; $display("[TB] FAIL refresh_grant: got ref=%b req=%b exp ref=0 req=1", b0.refresh_en, b0.sdram_req); end
        drive_hs(0, 1'b1, 1'b0, 32'h0);
        step();
        drive_hs(0, 1'b0, 1'b1, 32'h5A5A0001);
        checks++; if (b0.refresh_en !== 1'b0) begin errors++; $display("[TB] FAIL refresh_ack: got %b exp 0", b0.refresh_en); end
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        checks++; if (b0.refresh_en !== 1'b0) begin errors++; $display("[TB] FAIL refresh_rdy: got %b exp 0", b0.refresh_en); end
        step();
        checks++; if (b0.refresh_en !== 1'b1 || b0.slot_ok[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL refresh_back: got ref=%b ok=%b exp ref=1 ok=1", b0.refresh_en, b0.slot_ok[0]); end
        b0.vblank = 1'b0;
        step();
        checks++; if (b0.refresh_en !== 1'b0) begin errors++; $display("[TB] FAIL refresh_vblank_off: got %b exp 0", b0.refresh_en); end
    endtask

    task automatic test_loop_rst();
        logic [21:0] got;
        bit          to;
        logic [31:0] d;
        b0.slot_addr[36 +: 18] = 18'h2500;
        b0.slot_cs = 4'b0101;
        wait_req(0, got, to);
        checks++; if (to || got !== exp_addr(0, 2, 18'h2500)) begin
            errors++; $display("[TB] FAIL lrst_addr: got %h (timeout=%0d) exp %h", got, to, exp_addr(0, 2, 18'h2500)); end
        drive_hs(0, 1'b1, 1'b0, 32'h0);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        checks++; if (b0.slot_ok[0] !== 1'b1) begin errors++; $display("[TB] FAIL lrst_ok_before: got %b exp 1", b0.slot_ok[0]); end
        b0.loop_rst = 1'b1;
        b0.slot_cs  = 4'b0;
        step();
        b0.loop_rst = 1'b0;
        checks++; if (b0.sdram_req !== 1'b0 || b0.slot_ok !== 4'b0) begin
            errors++; $display("[TB] FAIL lrst_clear: got req=%b ok=%b exp req=0 ok=0000", b0.sdram_req, b0.slot_ok); end
        drive_hs(0, 1'b0, 1'b1, 32'h12345678);
        step();
        drive_hs(0, 1'b0, 1'b0, 32'h0);
        checks++; if (b0.slot_dout !== 128'h0 || b0.slot_ok !== 4'b0) begin
            errors++; $display("[TB] FAIL lrst_stale_rdy: got dout=%h ok=%b exp dout=0 ok=0000", b0.slot_dout, b0.slot_ok); end
        step();
        checks++; if (b0.sdram_req !== 1'b0) begin errors++; $display("[TB] FAIL lrst_idle: got %b exp 0", b0.sdram_req); end
        b0.slot_cs = 4'b0100;
        wait_req(0, got, to);
        checks++; if (to || got !== exp_addr(0, 2, 18'h2500)) begin
            errors++; $display("[TB] FAIL lrst_refetch: got %h (timeout=%0d) exp %h", got, to, exp_addr(0, 2, 18'h2500)); end
        d = $urandom;
        finish_fetch(0, 1, 0, d);
        step();
        checks++; if (b0.slot_ok[2] !== 1'b1 || b0.slot_dout[64 +: 32] !== d) begin
            errors++; $display("[TB] FAIL lrst_fill: got ok=%b dout=%h exp ok=1 dout=%h", b0.slot_ok[2], b0.slot_dout[64 +: 32], d); end
        b0.slot_cs = 4'b0;
        step();
    endtask

    // Both slots re-miss after every fill, so the grants must alternate.
    task automatic test_round_robin();
        logic [17:0] cur [4];
        logic [3:0]  pset;
        logic [21:0] got;
        bit          to;
        bit          found;
        int          ptr, pick, c;
        for (int i = 0; i < 4; i++) cur[i] = 18'h20;
        for (int i = 0; i < 4; i++) b1.slot_addr[18*i +: 18] = cur[i];
        b1.slot_cs = 4'b1010;
        pset = 4'b1010;
        ptr  = 3;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            pick  = 0;
            for (int j = 1; j <= 4; j++) begin
                c = (ptr + j) % 4;
                if (!found && pset[c]) begin pick = c; found = 1'b1; end
            end
            wait_req(1, got, to);
            checks++; if (to || got !== exp_addr(1, pick, cur[pick])) begin
                errors++; $display("[TB] FAIL rr_grant%0d: got %h (timeout=%0d) exp slot%0d addr %h", k, got, to, pick, exp_addr(1, pick, cur[pick])); end
            finish_fetch(1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
            ptr = pick;
            cur[pick] = cur[pick] + 18'($urandom_range(1, 4));
            b1.slot_addr[18*pick +: 18] = cur[pick];
        end
        b1.slot_cs = 4'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_fill();
        test_random_fills();
        test_fixed_priority();
        test_addr_change();
        test_downloading();
        test_refresh();
        test_loop_rst();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtframe_romrq_arb.md
Name: jtframe_romrq_arb

Overview:
- Parametrised N-slot SDRAM read arbiter.
- Successor to the fixed-slot ROM slot block used in game tops.
- Each slot gets a one-word tag cache, a per-slot SDRAM offset and a selectable arbitration mode (fixed priority or round-robin).
- Sits between the game-level ROM clients (CPUs, MCU, sound, GFX) and the jtframe SDRAM controller read port.

Parameters:
- SLOTS, 4, number of client slots (1..8).
- AW, 18, slot address width in 32-bit SDRAM words.
- OFFSETS, {8{22'd0}}, packed 8x22 vector; slot i offset is OFFSETS[22*i+:22]. Added to the slot address to form the SDRAM address.
- RR, 0, arbitration mode. 0 = fixed priority (lowest index wins). 1 = round-robin starting after the last granted slot.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- slot_cs  in  SLOTS  per-slot request enable.
- slot_addr  in  SLOTS*AW  packed word addresses; slot i at [AW*i+:AW].
- slot_ok  out  SLOTS  slot i data valid for its current address.
- slot_dout  out  SLOTS*32  packed cached words.
- sdram_req  out  1  read request to the SDRAM controller.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  data_read valid for one cycle.
- data_read  in  32  SDRAM read data.
- downloading  in  1  ROM download in progress.
- loop_rst  in  1  controller loop reset; same effect as rst on this block.
- vblank  in  1  vertical blank.
- refresh_en  out  1  refresh allowed.

Behaviour:
- Reset (rst or loop_rst, sampled on clk):
  - state=IDLE; all valid bits, tags and slot_dout cleared to 0.
  - slot_ok=0, sdram_req=0, sdram_addr=0, refresh_en=0.
  - Round-robin pointer set to SLOTS-1, so slot 0 has first priority.
- Per-slot hit:
  - hit_i = valid_i && tag_i==addr_i.
  - slot_ok_i is registered: slot_ok_i <= cs_i && hit_i && !downloading.
  - On a cache hit, ok rises 1 cycle after cs and stays high while cs and addr are steady.
  - A change of addr drops ok on the next cycle unless the new address hits.
- Pending: pend_i = cs_i && !hit_i && !downloading.
- States:
  - IDLE: if any pend, pick the winner g per RR. Latch g and tag_g<=addr_g. Drive sdram_addr <= addr_g + OFFSETS_g (22-bit, wrap modulo 2^22, AW zero-extended). Set sdram_req=1, go to REQ.
  - REQ: hold sdram_req and sdram_addr stable until sdram_ack=1. On ack, clear sdram_req and go to WAIT. If data_rdy arrives in the same cycle as ack, treat it as WAIT completion.
  - WAIT: on data_rdy, write slot_dout_g <= data_read, set valid_g=1 (the tag was latched at grant), and return to IDLE. In RR mode, update the pointer to g.
- Cache-miss latency:
  - Grant in IDLE: 1 cycle.
  - REQ: held until ack.
  - WAIT: until data_rdy.
  - ok rises the cycle after the fill.
  - Minimum is 4 cycles from cs to ok with ack and rdy each arriving 1 cycle after the previous step.
- Address changed mid-fetch: the fill still completes with the old tag. That slot then misses and is re-requested later; ok never shows stale data for the new address.
- cs dropped mid-fetch: the fetch completes and the cache is filled. No cancel.
- downloading=1:
  - All valid bits clear every cycle; slot_ok=0; no new grants.
  - A REQ/WAIT already in flight finishes its handshake, but the fill is discarded (valid stays 0).
- refresh_en = vblank && state==IDLE && no pend (registered).
- Only one outstanding SDRAM request at any time. A slot is never granted twice in a row in RR mode while another slot is pending.

Test Plan:
- Reset then slot0 cs, addr=0x100, OFFSETS0=0x2000 -> sdram_req with sdram_addr=0x2100. After ack and data_rdy with 0xDEADBEEF, slot_ok[0]=1 and slot_dout0=0xDEADBEEF; a repeat cs at 0x100 produces no new sdram_req.
- RR=0, slots 0, 2 and 3 missing simultaneously -> grants in order 0, 2, 3. RR=1 with slot1 always re-missing, plus slot3 pending -> grants alternate 1, 3, 1, 3.
- Slot1 addr changes from 0x10 to 0x11 during WAIT -> the fill stores tag 0x10, slot_ok[1] stays 0, then a second request for 0x11 is issued and ok rises only after the second fill.
- downloading asserted while valid caches are hit -> slot_ok falls to 0 the next cycle. An in-flight fill completes the handshake but ok stays 0. After downloading drops, the same address refetches.
- vblank=1 with no pending slots -> refresh_en=1. A miss arrives -> refresh_en=0 through the grant, ack and rdy cycles, then returns to 1.
- loop_rst pulsed in WAIT -> state IDLE, sdram_req=0, all slot_ok=0. A later stale data_rdy writes nothing.
